// File: rtl/mem_access_unit_pkg.sv
// Shared codes for the load/store unit.
//   - size_t and the address/data/byte-enable width constants
//   - mem_op_t   : load/store operation encoding from the execute stage
//   - mem_state_t: FSM state codes of mem_access_unit
//   - helper functions: store detection and natural-alignment check
package mem_access_unit_pkg;

    typedef int unsigned size_t;

    localparam size_t ADDR_W = 32;
    localparam size_t DATA_W = 32;
    localparam size_t BE_W   = DATA_W / 8;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUS  = 2'd1,
        MS_DATA = 2'd2,
        MS_RESP = 2'd3
    } mem_state_t;

    // True for the three store operations.
    function automatic logic op_is_store(input mem_op_t op);
        logic st;
        case (op)
            OP_SB, OP_SH, OP_SW: st = 1'b1;
            default:             st = 1'b0;
        endcase
        return st;
    endfunction

    // A halfword must sit on an even address, a word on a multiple of four.
    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] off);
        logic mis;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = off[0];
            OP_LW, OP_SW:         mis = (off != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and Avalon-style data-bus signals of the load/store unit.
//   master : the load/store unit (accepts requests, masters the data bus)
//   slave  : the surrounding datapath and the data memory
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    // execute-stage request / response
    logic                  req_valid;
    logic                  req_ready;
    mem_op_t               req_op;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_data;
    logic                  align_error;

    // data memory bus
    logic [ADDR_W-1:0]     address;
    logic                  read;
    logic                  write;
    logic [BE_W-1:0]       byteenable;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  waitrequest;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, readdata, waitrequest,
        output req_ready, resp_valid, resp_data, align_error,
               address, read, write, byteenable, writedata
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, readdata, waitrequest,
        input  req_ready, resp_valid, resp_data, align_error,
               address, read, write, byteenable, writedata
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the load/store unit.
//   op, off    : operation and byte offset (address bits 1:0)
//   wdata      : right-justified store data
//   rdata      : raw 32-bit bus read data
//   byteenable : lane enables for the access width and offset
//   wdata_rep  : store data replicated across every lane of its width
//   rdata_ext  : selected load lane(s), sign- or zero-extended to 32 bits
// Offsets are always truncated to the access width, so a misaligned access
// that is allowed to proceed uses the naturally aligned lane group.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_op_t           op,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   byteenable,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [1:0]        off_eff_s;
    logic [DATA_W-1:0] shifted_s;

    // Effective offset, lane enables and replicated store data per width.
    always_comb begin
        off_eff_s  = 2'b00;
        byteenable = 4'b0000;
        wdata_rep  = 32'h0000_0000;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                off_eff_s  = off;
                byteenable = 4'b0001 << off;
                wdata_rep  = {4{wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                off_eff_s  = {off[1], 1'b0};
                byteenable = 4'b0011 << {off[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
            end
            OP_LW, OP_SW: begin
                off_eff_s  = 2'b00;
                byteenable = 4'b1111;
                wdata_rep  = wdata;
            end
            default: begin
                off_eff_s  = 2'b00;
                byteenable = 4'b0000;
                wdata_rep  = 32'h0000_0000;
            end
        endcase
    end

    // Move the addressed lane down to bit 0 before extension.
    assign shifted_s = rdata >> {off_eff_s, 3'b000};

    // Sign- or zero-extend the selected lane(s); stores return nothing.
    always_comb begin
        rdata_ext = 32'h0000_0000;
        case (op)
            OP_LB:   rdata_ext = {{24{shifted_s[7]}}, shifted_s[7:0]};
            OP_LBU:  rdata_ext = {24'h00_0000, shifted_s[7:0]};
            OP_LH:   rdata_ext = {{16{shifted_s[15]}}, shifted_s[15:0]};
            OP_LHU:  rdata_ext = {16'h0000, shifted_s[15:0]};
            OP_LW:   rdata_ext = shifted_s;
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between the execute
// stage and an Avalon-style data memory port.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high reset, abandons any transaction
//   bus   : mem_access_unit_if.master - request/response handshake and the
//           data bus (address, read, write, byteenable, writedata,
//           readdata, waitrequest)
// All outputs are registered. Loads respond three cycles after acceptance,
// stores two, each waitrequest cycle adding one; misaligned accesses (when
// checked) respond after one cycle with align_error and never touch the bus.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit ADDR_ALIGN_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.master  bus
);

    localparam logic [1:0] ST_IDLE = MS_IDLE;
    localparam logic [1:0] ST_BUS  = MS_BUS;
    localparam logic [1:0] ST_DATA = MS_DATA;
    localparam logic [1:0] ST_RESP = MS_RESP;

    logic [1:0]        state_r;
    mem_op_t           op_r;
    logic [1:0]        off_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_data_r;
    logic              align_error_r;
    logic [ADDR_W-1:0] address_r;
    logic              read_r;
    logic              write_r;
    logic [BE_W-1:0]   byteenable_r;
    logic [DATA_W-1:0] writedata_r;

    mem_op_t           lane_op_s;
    logic [1:0]        lane_off_s;
    logic [BE_W-1:0]   lane_be_s;
    logic [DATA_W-1:0] lane_wdata_s;
    logic [DATA_W-1:0] lane_rdata_s;
    logic              accept_s;
    logic              misaligned_s;
    logic              is_store_s;

    // In IDLE the lane logic prepares the bus payload from the incoming
    // request; afterwards it works on the latched op for load extraction.
    always_comb begin
        if (state_r == ST_IDLE) begin
            lane_op_s  = bus.req_op;
            lane_off_s = bus.req_addr[1:0];
        end else begin
            lane_op_s  = op_r;
            lane_off_s = off_r;
        end
    end

    assign accept_s     = bus.req_valid && req_ready_r;
    assign misaligned_s = ADDR_ALIGN_CHECK && op_misaligned(bus.req_op, bus.req_addr[1:0]);
    assign is_store_s   = op_is_store(bus.req_op);

    mem_lane_align u_lane_align (
        .op         (lane_op_s),
        .off        (lane_off_s),
        .wdata      (bus.req_wdata),
        .rdata      (bus.readdata),
        .byteenable (lane_be_s),
        .wdata_rep  (lane_wdata_s),
        .rdata_ext  (lane_rdata_s)
    );

    // Request FSM: accept, drive the bus, capture load data, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            op_r          <= OP_LB;
            off_r         <= 2'b00;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_data_r   <= 32'h0000_0000;
            align_error_r <= 1'b0;
            address_r     <= 32'h0000_0000;
            read_r        <= 1'b0;
            write_r       <= 1'b0;
            byteenable_r  <= 4'b0000;
            writedata_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r        <= bus.req_op;
                        off_r       <= bus.req_addr[1:0];
                        req_ready_r <= 1'b0;
                        if (misaligned_s) begin
                            resp_valid_r  <= 1'b1;
                            align_error_r <= 1'b1;
                            resp_data_r   <= 32'h0000_0000;
                            state_r       <= ST_RESP;
                        end else begin
                            address_r    <= {bus.req_addr[31:2], 2'b00};
                            byteenable_r <= lane_be_s;
                            writedata_r  <= lane_wdata_s;
                            read_r       <= !is_store_s;
                            write_r      <= is_store_s;
                            state_r      <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    // Strobes and payload simply hold while the bus stalls.
                    if (!bus.waitrequest) begin
                        read_r  <= 1'b0;
                        write_r <= 1'b0;
                        if (write_r) begin
                            resp_valid_r <= 1'b1;
                            resp_data_r  <= 32'h0000_0000;
                            state_r      <= ST_RESP;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // readdata is valid exactly one cycle after the read.
                    resp_data_r  <= lane_rdata_s;
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_r  <= 1'b0;
                    resp_data_r   <= 32'h0000_0000;
                    align_error_r <= 1'b0;
                    req_ready_r   <= 1'b1;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    resp_valid_r  <= 1'b0;
                    resp_data_r   <= 32'h0000_0000;
                    align_error_r <= 1'b0;
                    read_r        <= 1'b0;
                    write_r       <= 1'b0;
                    req_ready_r   <= 1'b1;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_data   = resp_data_r;
    assign bus.align_error = align_error_r;
    assign bus.address     = address_r;
    assign bus.read        = read_r;
    assign bus.write       = write_r;
    assign bus.byteenable  = byteenable_r;
    assign bus.writedata   = writedata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random
// load/store traffic compared against a byte-level reference memory.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.ADDR_ALIGN_CHECK(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [31:0] bus_mem [16];   // memory behind the bus, written by the DUT
    logic [31:0] ref_mem [16];   // reference memory, written by the model

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input mem_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic bit op_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic bit op_signed(input mem_op_t op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic int eff_off(input mem_op_t op, input logic [31:0] addr);
        int o;
        o = int'(addr % 32'd4);
        return o - (o % op_size(op));
    endfunction

    function automatic logic [3:0] exp_be(input mem_op_t op, input logic [31:0] addr);
        logic [31:0] m;
        m = ((32'd1 << op_size(op)) - 32'd1) << eff_off(op, addr);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input mem_op_t op, input logic [31:0] wdata);
        case (op_size(op))
            1:       return (wdata & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (wdata & 32'h0000_FFFF) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input mem_op_t op, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (op_size(op) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * op_size(op))) - 32'd1);
        v = (word >> (8 * eff_off(op, addr))) & mask;
        if (op_signed(op) && (v > (mask >> 1))) v = v | ~mask;
        return v;
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] d;
        d = (a - BASE) >> 2;
        return int'(d[3:0]);
    endfunction

    // ---------------- one transaction, cycle by cycle ----------------
    task automatic run_access(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                              input int nwait, output logic [31:0] resp_seen);
        bit          mis, st, in_bus;
        int          resp_c;
        logic [31:0] exp_resp, slave_addr;
        logic [3:0]  be;
        logic [31:0] wd;
        mis      = (addr % op_size(op)) != 0;
        st       = op_store(op);
        resp_c   = mis ? 1 : (st ? nwait + 2 : nwait + 3);
        be       = exp_be(op, addr);
        wd       = exp_wdata(op, wdata);
        exp_resp = (mis || st) ? 32'h0 : exp_load(op, addr, ref_mem[widx(addr)]);
        slave_addr = 32'h0;
        resp_seen  = 32'h0;

        @(negedge clk);
        check_value("req_ready_idle", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.waitrequest = 1'b0;

        for (int c = 1; c <= resp_c + 1; c++) begin
            @(negedge clk);
            bus_if.req_valid   = 1'b0;
            bus_if.waitrequest = (!mis && c <= nwait);
            bus_if.readdata    = (!mis && !st && c == nwait + 2) ? bus_mem[widx(slave_addr)] : $urandom();
            in_bus = !mis && (c <= nwait + 1);
            check_value("read",  32'(bus_if.read),  32'(in_bus && !st));
            check_value("write", 32'(bus_if.write), 32'(in_bus && st));
            if (in_bus) begin
                check_value("address",    bus_if.address, {addr[31:2], 2'b00});
                check_value("byteenable", 32'(bus_if.byteenable), 32'(be));
                if (st) check_value("writedata", bus_if.writedata, wd);
            end
            if (in_bus && c == nwait + 1) begin
                if (bus_if.read) slave_addr = bus_if.address;
                if (bus_if.write) begin
                    for (int b = 0; b < 4; b++)
                        if (bus_if.byteenable[b])
                            bus_mem[widx(bus_if.address)][8*b +: 8] = bus_if.writedata[8*b +: 8];
                end
            end
            check_value("resp_valid", 32'(bus_if.resp_valid), 32'(c == resp_c));
            check_value("req_ready",  32'(bus_if.req_ready),  32'(c > resp_c));
            if (c == resp_c) begin
                resp_seen = bus_if.resp_data;
                check_value("resp_data",   bus_if.resp_data, exp_resp);
                check_value("align_error", 32'(bus_if.align_error), 32'(mis));
            end else begin
                check_value("resp_data_idle",   bus_if.resp_data, 32'h0);
                check_value("align_error_idle", 32'(bus_if.align_error), 32'h0);
            end
        end
        bus_if.waitrequest = 1'b0;
        if (st && !mis) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[widx(addr)][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        logic [2:0]  opr;
        bus_if.req_valid   = 1'b0;
        bus_if.req_op      = OP_LB;
        bus_if.req_addr    = 32'h0;
        bus_if.req_wdata   = 32'h0;
        bus_if.readdata    = 32'h0;
        bus_if.waitrequest = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_mem[i] = $urandom();
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[4] = 32'h8077_F0A5;
        ref_mem[4] = 32'h8077_F0A5;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_value("rst_read",        32'(bus_if.read), 32'h0);
        check_value("rst_write",       32'(bus_if.write), 32'h0);
        check_value("rst_byteenable",  32'(bus_if.byteenable), 32'h0);
        check_value("rst_address",     bus_if.address, 32'h0);
        check_value("rst_writedata",   bus_if.writedata, 32'h0);
        check_value("rst_resp_valid",  32'(bus_if.resp_valid), 32'h0);
        check_value("rst_resp_data",   bus_if.resp_data, 32'h0);
        check_value("rst_align_error", 32'(bus_if.align_error), 32'h0);
        check_value("rst_req_ready",   32'(bus_if.req_ready), 32'h1);
        reset = 1'b0;

        // directed loads from the preloaded word
        run_access(OP_LB,  32'hBFC0_0011, 32'h0, 0, r); check_value("lb_const",  r, 32'hFFFF_FFF0);
        run_access(OP_LBU, 32'hBFC0_0013, 32'h0, 0, r); check_value("lbu_const", r, 32'h0000_0080);
        run_access(OP_LH,  32'hBFC0_0012, 32'h0, 0, r); check_value("lh_const",  r, 32'hFFFF_8077);
        run_access(OP_LHU, 32'hBFC0_0010, 32'h0, 0, r); check_value("lhu_const", r, 32'h0000_F0A5);
        run_access(OP_LW,  32'hBFC0_0010, 32'h0, 0, r); check_value("lw_const",  r, 32'h8077_F0A5);
        // byte store then read-back
        run_access(OP_SB,  32'hBFC0_0012, 32'h1234_5678, 0, r);
        run_access(OP_LW,  32'hBFC0_0010, 32'h0, 0, r); check_value("lw_after_sb", r, 32'h8078_F0A5);
        // misaligned accesses
        run_access(OP_LW,  32'hBFC0_0002, 32'h0, 0, r);
        run_access(OP_SH,  32'hBFC0_0001, 32'hABCD, 0, r);
        // stalled word store and read-back
        run_access(OP_SW,  32'hBFC0_0020, 32'hDEAD_BEEF, 3, r);
        run_access(OP_LW,  32'hBFC0_0020, 32'h0, 1, r); check_value("lw_after_sw", r, 32'hDEAD_BEEF);

        // reset while a load is stalled on the bus
        @(negedge clk);
        bus_if.req_valid   = 1'b1;
        bus_if.req_op      = OP_LW;
        bus_if.req_addr    = 32'hBFC0_0010;
        bus_if.waitrequest = 1'b1;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        check_value("abort_read_before", 32'(bus_if.read), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_value("abort_read_async", 32'(bus_if.read), 32'h0);
        check_value("abort_ready_async", 32'(bus_if.req_ready), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_if.waitrequest = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_value("abort_no_resp",  32'(bus_if.resp_valid), 32'h0);
            check_value("abort_no_read",  32'(bus_if.read), 32'h0);
            check_value("abort_ready",    32'(bus_if.req_ready), 32'h1);
        end
        run_access(OP_LW, 32'hBFC0_0010, 32'h0, 0, r); check_value("lw_after_abort", r, 32'h8078_F0A5);

        // random traffic
        for (int n = 0; n < 250; n++) begin
            opr = 3'($urandom_range(0, 7));
            run_access(mem_op_t'(opr), BASE + 32'($urandom_range(0, 63)), $urandom(),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit between the CPU datapath and the Avalon-style data memory port.
- Accepts one load/store request at a time from the execute stage.
- Converts the request into a word-aligned bus transaction with the correct byteenable and lane-replicated writedata.
- Honours waitrequest and the fixed 1-cycle read latency.
- Returns the extracted, sign- or zero-extended load result, or a store completion, as a single-cycle response.

Parameters:
ADDR_ALIGN_CHECK, 1, when 1, misaligned halfword/word accesses raise align_error and issue no bus transaction.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request this cycle (high only in IDLE).
req_op  in  mem_op_t  LB, LBU, LH, LHU, LW, SB, SH, SW.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_data  out  32  extended load result; 0 for stores and errors.
align_error  out  1  qualifies resp_valid; misaligned access.
address  out  32  bus address, always {req_addr[31:2],2'b00}.
read  out  1  bus read strobe.
write  out  1  bus write strobe.
byteenable  out  4  lane enables, bit n = bits 8n+7:8n (little endian).
writedata  out  32  lane-replicated store data.
readdata  in  32  bus read data, valid the cycle after an accepted read.
waitrequest  in  1  bus stall; strobes and payload held while high.

Behaviour:
- Reset, asynchronous, any state: state=IDLE.
  - read, write, byteenable, address, writedata, resp_valid, resp_data and align_error all 0.
  - req_ready=1 once in IDLE.
  - Any in-flight transaction is abandoned, with no response.
- FSM states: IDLE, BUS, DATA, RESP.
- IDLE:
  - On req_valid && req_ready, latch op, addr and wdata.
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned and ADDR_ALIGN_CHECK=1 -> RESP with align_error=1 and resp_data=0; read and write never asserted.
  - Otherwise -> BUS.
- BUS:
  - Drive read (loads) or write (stores), plus address, byteenable and writedata.
  - Hold all of them stable while waitrequest=1.
  - On waitrequest=0: a store goes to RESP, a load goes to DATA.
  - Strobes deassert on leaving BUS.
- DATA: register readdata, extract the addressed lane(s), extend, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_data and align_error are valid only while resp_valid=1 and are 0 otherwise.
- Latency with no stalls, request accepted in cycle 0:
  - Load: read in cycle 1, data sampled in cycle 2, resp_valid in cycle 3.
  - Store: write in cycle 1, resp_valid in cycle 2.
  - Each waitrequest cycle adds 1.
- Lane rules, off=addr[1:0]:
  - Byte: byteenable=1<<off, writedata={4{wdata[7:0]}}.
  - Half: byteenable=4'b0011<<off, writedata={2{wdata[15:0]}}.
  - Word: byteenable=4'b1111, writedata=wdata.
  - Loads drive the same byteenable pattern as stores of the same width.
- Extension: LB/LH sign-extend from bit 7/15 of the selected lane; LBU/LHU zero-extend.
- No back-to-back acceptance: req_ready=0 in BUS, DATA and RESP, so at most one outstanding request.
- With ADDR_ALIGN_CHECK=0, misaligned accesses drop the low address bits for lane selection (off forced to 0 for words, off[0] forced to 0 for halves) and proceed normally.

Decomposition:
- The shared package (codes) gets:
  - the mem_op_t enum;
  - the mem_state_t enum;
  - width constants, using the existing size_t.
- One natural sub-module, mem_lane_align (combinational):
  - inputs: op and off;
  - outputs: byteenable and the replicated writedata;
  - on the read side: readdata -> extended result.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Preload word 0xBFC00010=0x8077F0A5, waitrequest=0; LB 0xBFC00011 -> byteenable=0010, resp_data=0xFFFFFFF0 on cycle 3.
- Same word:
  - LBU 0xBFC00013 -> 0x00000080;
  - LH 0xBFC00012 -> byteenable=1100, 0xFFFF8077;
  - LHU 0xBFC00010 -> 0x0000F0A5;
  - LW -> 0x8077F0A5.
- SB 0xBFC00012 wdata=0x12345678 -> write=1, address=0xBFC00010, byteenable=0100, writedata=0x78787878, resp_valid on cycle 2; following LW -> 0x8078F0A5.
- LW 0xBFC00002 -> no read or write ever asserted; resp_valid with align_error=1 and resp_data=0 one cycle after acceptance; same for SH 0xBFC00001.
- SW with waitrequest held high for 3 cycles -> write, address, byteenable and writedata constant across all 4 bus cycles; resp_valid on cycle 5; req_ready=0 throughout.
- Assert reset while a load is in the BUS state -> read drops immediately (async), no resp_valid ever appears, req_ready=1 after release; a new LW then completes normally.
